fifo_stream_reader: RTL

- Read-side companion for the synchronous FIFO.
- Drives the FIFO's rd_en/empty/dout read port, absorbing the FIFO's one-cycle read latency (data appears on dout the cycle after rd_en).
- Presents a registered valid/ready stream to downstream logic.
- Contains a small output buffer so that no combinational path runs from out_ready to fifo_rd_en, while still sustaining one word per cycle.

---
 rtl/fifo_reader_pkg.sv | 6 +
 rtl/fifo_reader_buf.sv | 56 +++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state type and constants for fifo_stream_reader.
//   No ports. Provides state_e {RUN, FLUSH} and BUF_DEPTH_MIN.
package fifo_reader_pkg;
  typedef enum logic {RUN, FLUSH} state_e;
  localparam int BUF_DEPTH_MIN = 2;
endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: DEPTH-entry register buffer with wrap-around pointers.
//   clk, nreset       clock, async active-low reset
//   capture_i/wdata_i write wdata_i at the write pointer
//   pop_i             advance the read pointer
//   clear_i           drop all entries and rewind both pointers (wins over capture)
//   count_o           entries held
//   head_o            entry at the read pointer, read from registered storage
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DW    = 104,
  parameter int DEPTH = 3,
  parameter int BW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          capture_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [BW-1:0] count_o,
  output logic [DW-1:0] head_o
);
  localparam int PW = $clog2(DEPTH > BUF_DEPTH_MIN ? DEPTH : BUF_DEPTH_MIN);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] count_q, count_d;
  logic          wr_en;
  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_en    = capture_i & ~clear_i;
    wr_ptr_d = clear_i ? '0 : capture_i ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = clear_i ? '0 : pop_i ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = clear_i ? '0 : count_q + BW'(capture_i) - BW'(pop_i);
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end
  // The issue logic reserves a slot for every read, so a capture never meets a full buffer.
  always_ff @(posedge clk) begin
    if (nreset) assert (!(wr_en && int'(count_q) == DEPTH));
  end
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a 1-cycle-latency FIFO read port into a valid/ready stream.
//   clk, nreset            clock, async active-low reset
//   fifo_dout, fifo_empty  FIFO read data (valid the cycle after fifo_rd_en) and empty flag
//   fifo_rd_en             FIFO read strobe, driven only from registers and fifo_empty
//   out_valid/out_data     stream head, out_ready downstream accept
//   buf_count              entries held in the output buffer
//   flush/flush_busy       only with FIFO_READER_FLUSH_EN: discard buffer and drain the FIFO
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DW        = 104,
  parameter int BUF_DEPTH = 3,
  parameter int BW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [BW-1:0] buf_count
`ifdef FIFO_READER_FLUSH_EN
  ,
  input  logic          flush,
  output logic          flush_busy
`endif
);
  state_e state_q, state_d;
  logic   inflight_q, room, pop, capture, clear;
  // Reads are issued only when the word already in flight plus the held words leave a free slot,
  // so out_ready never reaches fifo_rd_en.
  always_comb begin
    room       = (int'(buf_count) + int'(inflight_q)) < BUF_DEPTH;
    fifo_rd_en = nreset & ~fifo_empty & ((state_q == FLUSH) | room);
    pop        = out_valid & out_ready;
    capture    = inflight_q & (state_q == RUN);
`ifdef FIFO_READER_FLUSH_EN
    clear      = (state_q == RUN) & flush;
    state_d    = state_q == RUN ? (flush ? FLUSH : RUN)
                                : (~flush & fifo_empty & ~inflight_q ? RUN : FLUSH);
    flush_busy = state_q == FLUSH;
`else
    clear      = 1'b0;
    state_d    = RUN;
`endif
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
    end
  end
  fifo_reader_buf #(.DW(DW), .DEPTH(BUF_DEPTH), .BW(BW)) u_buf (
    .clk      (clk),
    .nreset   (nreset),
    .capture_i(capture),
    .wdata_i  (fifo_dout),
    .pop_i    (pop),
    .clear_i  (clear),
    .count_o  (buf_count),
    .head_o   (out_data)
  );
  assign out_valid = buf_count != '0;
endmodule
